// File: rtl/imem_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words and
// writes them to consecutive word addresses, then holds done_load_inst.
module imem_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  in_Clk,
  input  logic                  Rst_N,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_start_addr,
  input  logic [CNT_WIDTH-1:0]  in_num_words,
  input  logic [7:0]            in_byte,
  input  logic                  in_byte_valid,
  output logic                  out_byte_ready,
  output logic                  out_mem_wr_en,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [31:0]           out_mem_data,
  output logic                  out_busy,
  output logic                  done_load_inst
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [CNT_WIDTH-1:0]  r_remain;
  logic [1:0]            r_bcnt;
  logic [23:0]           r_word;
  logic [31:0]           r_mem_data;
  logic                  w_start_ok;
  logic                  w_xfer;

  assign w_start_ok = in_start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_xfer     = in_byte_valid & (r_state == S_COLLECT);

  // State register
  always_ff @(posedge in_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (in_start) begin
          w_next = (in_num_words == {CNT_WIDTH{1'b0}}) ? S_DONE : S_COLLECT;
        end else begin
          w_next = r_state;
        end
      end
      S_COLLECT: begin
        if (w_xfer && (r_bcnt == 2'd3)) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (r_remain == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
          w_next = S_DONE;
        end else begin
          w_next = S_COLLECT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch on start, pack bytes, advance address/count on write
  always_ff @(posedge in_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_addr     <= {DATA_WIDTH{1'b0}};
      r_remain   <= {CNT_WIDTH{1'b0}};
      r_bcnt     <= 2'd0;
      r_word     <= 24'd0;
      r_mem_addr <= {DATA_WIDTH{1'b0}};
      r_mem_data <= 32'd0;
    end else if (w_start_ok) begin
      r_addr   <= {in_start_addr[DATA_WIDTH-1:2], 2'b00};
      r_remain <= in_num_words;
      r_bcnt   <= 2'd0;
    end else if (w_xfer) begin
      r_bcnt <= r_bcnt + 2'd1;
      case (r_bcnt)
        2'd0: r_word[7:0]   <= in_byte;
        2'd1: r_word[15:8]  <= in_byte;
        2'd2: r_word[23:16] <= in_byte;
        2'd3: begin
          // Output registers load here so they are stable for the whole WRITE cycle
          r_mem_data <= {in_byte, r_word};
          r_mem_addr <= r_addr;
        end
        default: r_word <= r_word;
      endcase
    end else if (r_state == S_WRITE) begin
      r_addr   <= r_addr + DATA_WIDTH'(4);
      r_remain <= r_remain - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_byte_ready = (r_state == S_COLLECT);
  assign out_mem_wr_en  = (r_state == S_WRITE);
  assign out_busy       = (r_state == S_COLLECT) | (r_state == S_WRITE);
  assign done_load_inst = (r_state == S_DONE);
  assign out_mem_addr   = r_mem_addr;
  assign out_mem_data   = r_mem_data;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued when a load is set up
// and popped whenever the loader strobes a write.
module tb_imem_loader;

  logic        in_Clk;
  logic        Rst_N;
  logic        in_start;
  logic [63:0] in_start_addr;
  logic [15:0] in_num_words;
  logic [7:0]  in_byte;
  logic        in_byte_valid;
  logic        out_byte_ready;
  logic        out_mem_wr_en;
  logic [63:0] out_mem_addr;
  logic [31:0] out_mem_data;
  logic        out_busy;
  logic        done_load_inst;

  logic [95:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  int          n_wr;
  int          cyc;
  int          last_wr_cyc;

  imem_loader #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .in_Clk        (in_Clk),
    .Rst_N         (Rst_N),
    .in_start      (in_start),
    .in_start_addr (in_start_addr),
    .in_num_words  (in_num_words),
    .in_byte       (in_byte),
    .in_byte_valid (in_byte_valid),
    .out_byte_ready(out_byte_ready),
    .out_mem_wr_en (out_mem_wr_en),
    .out_mem_addr  (out_mem_addr),
    .out_mem_data  (out_mem_data),
    .out_busy      (out_busy),
    .done_load_inst(done_load_inst)
  );

  initial begin
    in_Clk = 1'b0;
    forever #5 in_Clk = ~in_Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [95:0] e;
    @(posedge in_Clk);
    #1;
    cyc++;
    if (out_mem_wr_en === 1'b1) begin
      n_wr++;
      last_wr_cyc = cyc;
      chk("ready_in_write", 64'(out_byte_ready), 64'd0);
      chk("busy_in_write", 64'(out_busy), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", out_mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", out_mem_addr, e[95:32]);
        chk("wr_data", 64'(out_mem_data), 64'(e[31:0]));
      end
    end
  endtask

  task automatic start(input logic [63:0] addr, input logic [15:0] cnt);
    in_start      = 1'b1;
    in_start_addr = addr;
    in_num_words  = cnt;
    tick();
    in_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic took;
    took = 1'b0;
    in_byte       = b;
    in_byte_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      took = out_byte_ready;
      tick();
    end
    in_byte_valid = 1'b0;
    if (!took) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (stall) tick();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done_load_inst !== 1'b1; i++) tick();
    chk("done_reached", 64'(done_load_inst), 64'd1);
  endtask

  initial begin
    int wr0;
    int rdy_cyc;
    n_cmp = 0; n_bad = 0; n_wr = 0; cyc = 0; last_wr_cyc = 0;
    Rst_N = 1'b0; in_start = 1'b0; in_start_addr = 64'd0; in_num_words = 16'd0;
    in_byte = 8'd0; in_byte_valid = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_ready", 64'(out_byte_ready), 64'd0);
    chk("rst_wr_en", 64'(out_mem_wr_en), 64'd0);
    chk("rst_addr", out_mem_addr, 64'd0);
    chk("rst_data", 64'(out_mem_data), 64'd0);
    Rst_N = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 64'(out_busy), 64'd0);
    chk("idle_done", 64'(done_load_inst), 64'd0);
    chk("idle_ready", 64'(out_byte_ready), 64'd0);

    // Single word
    wr0 = n_wr;
    exp_q.push_back({64'h10570, 32'h0000_0513});
    start(64'h10570, 16'd1);
    rdy_cyc = cyc;
    chk("start_ready", 64'(out_byte_ready), 64'd1);
    chk("start_busy", 64'(out_busy), 64'd1);
    send_word(32'h0000_0513, 1'b0);
    chk("wr_latency", 64'(last_wr_cyc), 64'(rdy_cyc + 4));
    tick();
    chk("single_done", 64'(done_load_inst), 64'd1);
    chk("single_nwr", 64'(n_wr - wr0), 64'd1);

    // Two words with stalls, bytes offered in DONE must not be taken
    wr0 = n_wr;
    exp_q.push_back({64'h10570, 32'h0010_0093});
    exp_q.push_back({64'h10574, 32'h0020_0113});
    start(64'h10573, 16'd2);
    chk("restart_done_drop", 64'(done_load_inst), 64'd0);
    send_word(32'h0010_0093, 1'b1);
    send_word(32'h0020_0113, 1'b1);
    wait_done();
    chk("two_nwr", 64'(n_wr - wr0), 64'd2);
    in_byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_ready_low", 64'(out_byte_ready), 64'd0);
    end
    in_byte_valid = 1'b0;

    // Zero count from IDLE
    Rst_N = 1'b0; tick(); Rst_N = 1'b1; tick();
    chk("zero_pre_done", 64'(done_load_inst), 64'd0);
    wr0 = n_wr;
    start(64'h5000, 16'd0);
    chk("zero_done", 64'(done_load_inst), 64'd1);
    chk("zero_busy", 64'(out_busy), 64'd0);
    repeat (3) tick();
    chk("zero_nwr", 64'(n_wr - wr0), 64'd0);

    // Start while busy is ignored
    wr0 = n_wr;
    exp_q.push_back({64'h2000, 32'h4433_2211});
    start(64'h2000, 16'd1);
    send_byte(8'h11);
    in_start = 1'b1; in_start_addr = 64'h9000; in_num_words = 16'd5;
    send_byte(8'h22);
    in_start = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    tick();
    chk("busy_start_done", 64'(done_load_inst), 64'd1);
    repeat (3) tick();
    chk("busy_start_nwr", 64'(n_wr - wr0), 64'd1);

    // Reset mid-word
    wr0 = n_wr;
    start(64'h3000, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 Rst_N = 1'b0;
    #1;
    chk("midrst_ready", 64'(out_byte_ready), 64'd0);
    chk("midrst_busy", 64'(out_busy), 64'd0);
    tick(); tick();
    Rst_N = 1'b1;
    repeat (2) tick();
    chk("midrst_done", 64'(done_load_inst), 64'd0);
    chk("midrst_nwr", 64'(n_wr - wr0), 64'd0);
    exp_q.push_back({64'h0, 32'hDEAD_BEEF});
    start(64'h0, 16'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    tick();
    chk("midrst_reload_done", 64'(done_load_inst), 64'd1);

    // Address wrap, then restart from DONE
    wr0 = n_wr;
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678});
    exp_q.push_back({64'h0, 32'h9ABC_DEF0});
    start(64'hFFFF_FFFF_FFFF_FFFC, 16'd2);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'h9ABC_DEF0, 1'b0);
    wait_done();
    chk("wrap_nwr", 64'(n_wr - wr0), 64'd2);
    exp_q.push_back({64'h40, 32'hCAFE_F00D});
    start(64'h41, 16'd1);
    chk("fresh_done_clear", 64'(done_load_inst), 64'd0);
    chk("fresh_ready", 64'(out_byte_ready), 64'd1);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
